cu_multicycle: RTL and testbench
================================

Name: cu_multicycle

Overview:
- Parametrised multi-cycle successor to the single-cycle RV32I control unit.
- Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB states and drives datapath selects, write-enable and PC update at the correct cycle, which removes the missing writeback delay.
- Adds full branch set (signed/unsigned), JAL/JALR, LUI/AUIPC, SLT/SLTU/SRA, memory handshakes, a memory timeout, and illegal-opcode trapping.

Parameters:
- ALUOP_W, 4: width of ALUop; must be >=4, upper bits zero.
- MEM_TIMEOUT, 0: max wait cycles in FETCH/MEM before fault; 0 = wait forever.
- CNT_W, 8: width of wait counter; MEM_TIMEOUT < 2**CNT_W.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous active-high reset.
- I  in  32  instruction word from imem; sampled only in FETCH when instr_valid=1.
- instr_valid  in  1  imem data valid.
- mem_ready  in  1  dmem access complete.
- BrEq  in  1  branch comparator equal.
- BrLt  in  1  branch comparator less-than (signedness per BrUn).
- ALUop  out  ALUOP_W  ALU operation.
- ImmSel  out  3  0=I, 1=S, 2=B, 3=U, 4=J.
- ASel  out  1  0=rs1, 1=PC.
- BSel  out  1  0=rs2, 1=imm.
- BrUn  out  1  unsigned compare.
- PCSel  out  1  0=PC+4, 1=ALU result.
- PCEn  out  1  PC load strobe, one cycle.
- WBSel  out  2  0=dmem, 1=ALU, 2=PC+4.
- wEn  out  1  regfile write strobe, one cycle.
- MemRW  out  1  1=write.
- mem_req  out  1  dmem request; held until mem_ready.
- instr_req  out  1  imem request in FETCH.
- fault  out  2  sticky: 0=none, 1=illegal opcode, 2=timeout.

Behaviour:
- Reset (rst=1 at edge, any state, including mid-MEM): state=FETCH, ir=32'h00000013, counter=0, fault=0.
- All outputs are 0 during the reset cycle. An in-flight request is abandoned; mem_ready arriving after reset is ignored.
- Outputs are decoded from state plus the latched ir; I never reaches the outputs combinationally. PCSel in EXEC is the only output that depends combinationally on BrEq/BrLt.
- FETCH:
  - instr_req=1.
  - On instr_valid: ir<=I, go to DECODE.
  - Otherwise stay and increment counter.
- DECODE (1 cycle):
  - Selects are valid for ir; no strobes.
  - Unknown opcode: fault<=1, go to HALT.
- EXEC (1 cycle), opcode encodings:
  - R (0110011): BSel=0, WBSel=1. funct3/ALUop:
    - 000: ADD 1001, or SUB 0001 if I[30].
    - 001: SLL 0101.
    - 010: SLT 0110.
    - 011: SLTU 0111.
    - 100: XOR 0010.
    - 101: SRL 1101, or SRA 1110 if I[30].
    - 110: OR 0011.
    - 111: AND 0100.
  - I-ALU (0010011): same mapping, BSel=1, ImmSel=0. I[30] selects SRA only when funct3=101 (never SUB).
  - Load (0000011) / store (0100011): ADD, BSel=1, ImmSel=0 for load and 1 for store.
  - LUI: ALUop=1010 (pass B), ImmSel=3.
  - AUIPC: ADD, ASel=1, ImmSel=3.
  - JAL: ADD, ASel=1, ImmSel=4.
  - JALR: ADD, ASel=0, ImmSel=0.
  - Branch (1100011): ADD, ASel=1, BSel=1, ImmSel=2, BrUn=funct3[1]. Taken rule:
    - 000 BrEq.
    - 001 !BrEq.
    - 100/110 BrLt.
    - 101/111 !BrLt.
    - funct3 010/011: fault=1, HALT.
  - Branch completes in EXEC: PCSel=taken, PCEn=1, go to FETCH.
  - Load/store go to MEM. All other instructions go to WB.
- MEM:
  - mem_req=1; MemRW=1 for store, 0 for load. Selects held stable.
  - On mem_ready: load goes to WB; store pulses PCEn=1 (PCSel=0) and goes to FETCH.
- WB (1 cycle):
  - wEn=1, PCEn=1.
  - WBSel: 0 for load, 2 for JAL/JALR, 1 otherwise.
  - PCSel=1 for JAL/JALR, else 0. ALU inputs held from EXEC.
  - Go to FETCH.
- Write to rd=x0 still pulses wEn; the regfile ignores it.
- Timeout:
  - counter clears on entry to FETCH/MEM and increments each waiting cycle.
  - If MEM_TIMEOUT>0 and counter==MEM_TIMEOUT without valid/ready: fault<=2, go to HALT.
  - Valid/ready arriving in that same cycle wins (no fault).
- HALT: all strobes 0, stays until rst. fault holds its value.
- Cycle counts with zero-wait memory (FETCH=1 cycle, MEM=1 cycle):
  - branch: 3.
  - ALU/LUI/AUIPC/JAL/JALR: 4.
  - store: 4.
  - load: 5.

Test Plan:
- ADD x3,x1,x2 (0x002081B3), instr_valid immediate -> DECODE; EXEC ALUop=1001, BSel=0; WB wEn=1, WBSel=1, PCEn=1; back in FETCH on cycle 5.
- SRAI (0x4020D093) then SUB (0x402081B3) -> ALUop=1110 then 0001; ADDI with I[30]=1 -> 1001.
- BLTU (funct3=110) with BrLt=1 -> EXEC BrUn=1, PCSel=1, PCEn=1, wEn never asserted; BNE with BrEq=1 -> PCSel=0.
- LW with mem_ready delayed 3 cycles -> mem_req high 4 cycles, MemRW=0, then WB wEn=1, WBSel=0; rst asserted on 2nd wait cycle -> FETCH next cycle, all outputs 0.
- MEM_TIMEOUT=4, mem_ready never asserted -> fault=2 after 4 wait cycles, HALT with no strobes until rst.
- Opcode 0x7F -> fault=1 after DECODE, PCEn/wEn never pulse; JAL -> WB WBSel=2, PCSel=1, ImmSel=4.

Source files
------------

// File: rtl/cu_multicycle.sv
// Multi-cycle RV32I control unit: walks each instruction through FETCH/DECODE/EXEC/MEM/WB
// and raises datapath selects and one-cycle strobes from the state plus the latched instruction.
module cu_multicycle #(
    parameter int ALUOP_W     = 4,
    parameter int MEM_TIMEOUT = 0,
    parameter int CNT_W       = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [31:0]        I,
    input  logic               instr_valid,
    input  logic               mem_ready,
    input  logic               BrEq,
    input  logic               BrLt,
    output logic [ALUOP_W-1:0] ALUop,
    output logic [2:0]         ImmSel,
    output logic               ASel,
    output logic               BSel,
    output logic               BrUn,
    output logic               PCSel,
    output logic               PCEn,
    output logic [1:0]         WBSel,
    output logic               wEn,
    output logic               MemRW,
    output logic               mem_req,
    output logic               instr_req,
    output logic [1:0]         fault
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_IMM   = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [CNT_W-1:0] TMO_C = CNT_W'(MEM_TIMEOUT);

    // funct3 -> ALU code; alt (I[30]) picks SUB/SRA where the encoding allows it
    function automatic logic [3:0] alu_decode(input logic [6:0] op, input logic [2:0] f3, input logic alt);
        logic [3:0] code;
        code = 4'b1001;
        if (op == OP_LUI) begin
            code = 4'b1010;
        end else if ((op == OP_R) || (op == OP_IMM)) begin
            case (f3)
                3'b000:  code = (alt && (op == OP_R)) ? 4'b0001 : 4'b1001;
                3'b001:  code = 4'b0101;
                3'b010:  code = 4'b0110;
                3'b011:  code = 4'b0111;
                3'b100:  code = 4'b0010;
                3'b101:  code = alt ? 4'b1110 : 4'b1101;
                3'b110:  code = 4'b0011;
                3'b111:  code = 4'b0100;
                default: code = 4'b1001;
            endcase
        end else begin
            code = 4'b1001;
        end
        return code;
    endfunction

    state_t           state_r, next_s;
    logic [31:0]      ir_r;
    logic [CNT_W-1:0] cnt_r;
    logic [1:0]       fault_r, fault_nxt_s;

    logic [6:0] opcode_s;
    logic [2:0] funct3_s;
    logic is_r_s, is_imm_s, is_ld_s, is_st_s, is_lui_s, is_auipc_s, is_jal_s, is_jalr_s, is_br_s;
    logic legal_s, br_bad_s, br_taken_s, tmo_s, sel_on_s;
    logic [3:0] alu4_s;
    logic [2:0] imm_s;
    logic [1:0] wbsel_s;
    logic unused_ir_s;

    assign opcode_s   = ir_r[6:0];
    assign funct3_s   = ir_r[14:12];
    assign is_r_s     = (opcode_s == OP_R);
    assign is_imm_s   = (opcode_s == OP_IMM);
    assign is_ld_s    = (opcode_s == OP_LOAD);
    assign is_st_s    = (opcode_s == OP_STORE);
    assign is_lui_s   = (opcode_s == OP_LUI);
    assign is_auipc_s = (opcode_s == OP_AUIPC);
    assign is_jal_s   = (opcode_s == OP_JAL);
    assign is_jalr_s  = (opcode_s == OP_JALR);
    assign is_br_s    = (opcode_s == OP_BR);
    assign legal_s    = is_r_s | is_imm_s | is_ld_s | is_st_s | is_lui_s | is_auipc_s
                      | is_jal_s | is_jalr_s | is_br_s;
    assign br_bad_s   = is_br_s && (funct3_s[2:1] == 2'b01);
    assign tmo_s      = (MEM_TIMEOUT > 0) && (cnt_r == TMO_C);
    assign alu4_s     = alu_decode(opcode_s, funct3_s, ir_r[30]);
    assign imm_s      = is_st_s ? 3'd1 : is_br_s ? 3'd2 : (is_lui_s | is_auipc_s) ? 3'd3
                      : is_jal_s ? 3'd4 : 3'd0;
    assign wbsel_s    = is_ld_s ? 2'd0 : (is_jal_s | is_jalr_s) ? 2'd2 : 2'd1;
    assign sel_on_s   = legal_s && ((state_r == S_DECODE) || (state_r == S_EXEC)
                      || (state_r == S_MEM) || (state_r == S_WB));
    assign unused_ir_s = ^{ir_r[31], ir_r[29:15], ir_r[11:7]};

    // Branch outcome; only consumed combinationally in EXEC
    always_comb begin
        case (funct3_s)
            3'b000:          br_taken_s = BrEq;
            3'b001:          br_taken_s = ~BrEq;
            3'b100, 3'b110:  br_taken_s = BrLt;
            3'b101, 3'b111:  br_taken_s = ~BrLt;
            default:         br_taken_s = 1'b0;
        endcase
    end

    // State, instruction, wait counter and sticky fault registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= S_FETCH;
            ir_r    <= 32'h0000_0013;
            cnt_r   <= '0;
            fault_r <= 2'd0;
        end else begin
            state_r <= next_s;
            fault_r <= fault_nxt_s;
            if ((state_r == S_FETCH) && instr_valid) begin
                ir_r <= I;
            end else begin
                ir_r <= ir_r;
            end
            // counter restarts on every state change, so entry into FETCH/MEM sees zero
            if (next_s != state_r) begin
                cnt_r <= '0;
            end else if ((state_r == S_FETCH) || (state_r == S_MEM)) begin
                cnt_r <= cnt_r + CNT_W'(1);
            end else begin
                cnt_r <= cnt_r;
            end
        end
    end

    // Next-state and fault update
    always_comb begin
        next_s      = state_r;
        fault_nxt_s = fault_r;
        case (state_r)
            S_FETCH: begin
                if (instr_valid) begin
                    next_s = S_DECODE;
                end else if (tmo_s) begin
                    next_s      = S_HALT;
                    fault_nxt_s = 2'd2;
                end else begin
                    next_s = S_FETCH;
                end
            end
            S_DECODE: begin
                if (legal_s) begin
                    next_s = S_EXEC;
                end else begin
                    next_s      = S_HALT;
                    fault_nxt_s = 2'd1;
                end
            end
            S_EXEC: begin
                if (br_bad_s) begin
                    next_s      = S_HALT;
                    fault_nxt_s = 2'd1;
                end else if (is_br_s) begin
                    next_s = S_FETCH;
                end else if (is_ld_s || is_st_s) begin
                    next_s = S_MEM;
                end else begin
                    next_s = S_WB;
                end
            end
            S_MEM: begin
                if (mem_ready) begin
                    next_s = is_st_s ? S_FETCH : S_WB;
                end else if (tmo_s) begin
                    next_s      = S_HALT;
                    fault_nxt_s = 2'd2;
                end else begin
                    next_s = S_MEM;
                end
            end
            S_WB:    next_s = S_FETCH;
            S_HALT:  next_s = S_HALT;
            default: next_s = S_FETCH;
        endcase
    end

    // Output decode; everything is forced low while rst is asserted
    always_comb begin
        ALUop     = '0;
        ImmSel    = 3'd0;
        ASel      = 1'b0;
        BSel      = 1'b0;
        BrUn      = 1'b0;
        PCSel     = 1'b0;
        PCEn      = 1'b0;
        WBSel     = 2'd0;
        wEn       = 1'b0;
        MemRW     = 1'b0;
        mem_req   = 1'b0;
        instr_req = 1'b0;
        fault     = 2'd0;
        if (rst) begin
            fault = 2'd0;
        end else begin
            fault = fault_r;
            if (sel_on_s) begin
                ALUop  = ALUOP_W'(alu4_s);
                ImmSel = imm_s;
                ASel   = is_auipc_s | is_jal_s | is_br_s;
                BSel   = ~is_r_s;
                BrUn   = is_br_s & funct3_s[1];
                WBSel  = wbsel_s;
            end else begin
                ALUop = '0;
            end
            case (state_r)
                S_FETCH: instr_req = 1'b1;
                S_EXEC: begin
                    if (is_br_s && !br_bad_s) begin
                        PCSel = br_taken_s;
                        PCEn  = 1'b1;
                    end else begin
                        PCEn = 1'b0;
                    end
                end
                S_MEM: begin
                    mem_req = 1'b1;
                    MemRW   = is_st_s;
                    if (mem_ready && is_st_s) begin
                        PCEn = 1'b1;
                    end else begin
                        PCEn = 1'b0;
                    end
                end
                S_WB: begin
                    wEn   = 1'b1;
                    PCEn  = 1'b1;
                    PCSel = is_jal_s | is_jalr_s;
                end
                default: instr_req = 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_cu_multicycle.sv
// Randomised self-checking bench for cu_multicycle against a per-instruction cycle model.
module tb_cu_multicycle;

    localparam int TMO = 4;

    typedef enum int {C_R, C_I, C_LD, C_ST, C_LUI, C_AUIPC, C_JAL, C_JALR, C_BR, C_ILL} cls_t;

    localparam logic [6:0] OPC [9] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
                                       7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111,
                                       7'b1100011};
    // ADD SLL SLT SLTU XOR SRL OR AND
    localparam logic [3:0] ALU_TAB [8] = '{4'd9, 4'd5, 4'd6, 4'd7, 4'd2, 4'd13, 4'd3, 4'd4};

    logic        clk = 1'b0;
    logic        rst, instr_valid, mem_ready, BrEq, BrLt;
    logic [31:0] I;
    logic [3:0]  ALUop;
    logic [2:0]  ImmSel;
    logic        ASel, BSel, BrUn, PCSel, PCEn, wEn, MemRW, mem_req, instr_req;
    logic [1:0]  WBSel, fault;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    cu_multicycle #(.ALUOP_W(4), .MEM_TIMEOUT(TMO), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .I(I), .instr_valid(instr_valid), .mem_ready(mem_ready),
        .BrEq(BrEq), .BrLt(BrLt), .ALUop(ALUop), .ImmSel(ImmSel), .ASel(ASel), .BSel(BSel),
        .BrUn(BrUn), .PCSel(PCSel), .PCEn(PCEn), .WBSel(WBSel), .wEn(wEn), .MemRW(MemRW),
        .mem_req(mem_req), .instr_req(instr_req), .fault(fault)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [4:0] strb();
        return {instr_req, mem_req, MemRW, wEn, PCEn};
    endfunction

    function automatic logic [19:0] all_outs();
        return {ALUop, ImmSel, ASel, BSel, BrUn, PCSel, PCEn, WBSel, wEn, MemRW, mem_req,
                instr_req, fault};
    endfunction

    function automatic cls_t cls_of(input logic [31:0] w);
        for (int k = 0; k < 9; k++) begin
            if (w[6:0] == OPC[k]) return cls_t'(k);
        end
        return C_ILL;
    endfunction

    function automatic logic [3:0] m_alu(input logic [31:0] w);
        cls_t c = cls_of(w);
        logic [2:0] f3 = w[14:12];
        if (c == C_LUI) return 4'd10;
        if (c == C_R || c == C_I) begin
            if (f3 == 3'd5 && w[30]) return 4'd14;
            if (c == C_R && f3 == 3'd0 && w[30]) return 4'd1;
            return ALU_TAB[f3];
        end
        return 4'd9;
    endfunction

    function automatic logic [2:0] m_imm(input cls_t c);
        case (c)
            C_ST:          return 3'd1;
            C_BR:          return 3'd2;
            C_LUI, C_AUIPC: return 3'd3;
            C_JAL:         return 3'd4;
            default:       return 3'd0;
        endcase
    endfunction

    function automatic logic m_taken(input logic [2:0] f3, input logic beq, input logic blt);
        case (f3)
            3'd0:       return beq;
            3'd1:       return !beq;
            3'd4, 3'd6: return blt;
            default:    return !blt;
        endcase
    endfunction

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic check_sel(input string pfx, input logic [31:0] w);
        cls_t c = cls_of(w);
        check({pfx, "_alu"}, ALUop, m_alu(w));
        check({pfx, "_imm"}, ImmSel, m_imm(c));
        check({pfx, "_asel"}, ASel, (c == C_AUIPC || c == C_JAL || c == C_BR));
        check({pfx, "_bsel"}, BSel, (c != C_R));
        check({pfx, "_brun"}, BrUn, (c == C_BR) ? w[13] : 1'b0);
    endtask

    task automatic do_reset();
        rst = 1'b1; instr_valid = 1'b0; mem_ready = 1'b0;
        #1;
        check("rst_outs", all_outs(), 20'd0);
        adv();
        rst = 1'b0;
    endtask

    // Drives one instruction end to end; waits above TMO force a timeout, rst_at>=0 resets mid-MEM
    task automatic run_instr(input logic [31:0] w, input int fw, input int mw,
                             input logic beq, input logic blt, input int rst_at);
        cls_t c = cls_of(w);
        logic st = (c == C_ST);
        int n;
        if (fw > TMO) begin
            instr_valid = 1'b0; n = 0;
            for (int k = 0; k < 3 * TMO; k++) begin
                #1;
                if (fault != 2'd0) break;
                if (instr_req) n++;
                adv();
            end
            check("fetch_tmo_cycles", n, TMO + 1);
            check("fetch_tmo_fault", fault, 2'd2);
            check("fetch_tmo_halt", strb(), 5'd0);
            adv();
            instr_valid = 1'b1; I = w;
            #1 check("halt_hold", {fault, strb()}, {2'd2, 5'd0});
            adv();
            do_reset();
            return;
        end
        for (int k = 0; k < fw; k++) begin
            instr_valid = 1'b0; I = $urandom;
            #1 check("fetch_wait", strb(), 5'b10000);
            adv();
        end
        instr_valid = 1'b1; I = w;
        #1 check("fetch", strb(), 5'b10000);
        adv();
        instr_valid = 1'b0; I = $urandom;
        #1 check("dec_strb", strb(), 5'd0);
        if (c == C_ILL) begin
            adv();
            #1 check("ill_fault", fault, 2'd1);
            check("ill_halt", strb(), 5'd0);
            adv();
            #1 check("ill_hold", {fault, strb()}, {2'd1, 5'd0});
            adv();
            do_reset();
            return;
        end
        check_sel("dec", w);
        adv();
        BrEq = beq; BrLt = blt;
        #1 check_sel("exe", w);
        if (c == C_BR) begin
            if (w[14:13] == 2'b01) begin
                check("brbad_strb", strb(), 5'd0);
                adv();
                #1 check("brbad_fault", {fault, strb()}, {2'd1, 5'd0});
                adv();
                do_reset();
                return;
            end
            check("br_strb", strb(), 5'b00001);
            check("br_pcsel", PCSel, m_taken(w[14:12], beq, blt));
            adv();
            return;
        end
        check("exe_strb", strb(), 5'd0);
        adv();
        if (c == C_LD || c == C_ST) begin
            if (mw > TMO) begin
                mem_ready = 1'b0; n = 0;
                for (int k = 0; k < 3 * TMO; k++) begin
                    #1;
                    if (fault != 2'd0) break;
                    if (mem_req) n++;
                    adv();
                end
                check("mem_tmo_cycles", n, TMO + 1);
                check("mem_tmo_fault", fault, 2'd2);
                check("mem_tmo_halt", strb(), 5'd0);
                adv();
                mem_ready = 1'b1;
                #1 check("mem_halt_hold", {fault, strb()}, {2'd2, 5'd0});
                adv();
                do_reset();
                return;
            end
            for (int k = 0; k < mw; k++) begin
                mem_ready = 1'b0;
                if (k == rst_at) begin
                    rst = 1'b1;
                    #1 check("midmem_rst_outs", all_outs(), 20'd0);
                    adv();
                    rst = 1'b0; mem_ready = 1'b1;
                    #1 check("post_rst_fetch", {fault, strb()}, {2'd0, 5'b10000});
                    adv();
                    mem_ready = 1'b0;
                    return;
                end
                #1 check("mem_wait", strb(), {1'b0, 1'b1, st, 1'b0, 1'b0});
                check("mem_alu", ALUop, m_alu(w));
                adv();
            end
            mem_ready = 1'b1;
            #1 check("mem_done", strb(), {1'b0, 1'b1, st, 1'b0, st});
            if (st) check("st_pcsel", PCSel, 1'b0);
            adv();
            mem_ready = 1'b0;
            if (st) return;
        end
        #1 check("wb_strb", strb(), 5'b00011);
        check("wb_wbsel", WBSel, (c == C_LD) ? 2'd0 : (c == C_JAL || c == C_JALR) ? 2'd2 : 2'd1);
        check("wb_pcsel", PCSel, (c == C_JAL || c == C_JALR));
        check("wb_alu", ALUop, m_alu(w));
        adv();
    endtask

    initial begin
        logic [31:0] w;
        int ci;
        rst = 1'b1; instr_valid = 1'b0; mem_ready = 1'b0; BrEq = 1'b0; BrLt = 1'b0;
        I = 32'h0000_0013;
        #1 check("reset_outs", all_outs(), 20'd0);
        adv();
        rst = 1'b0;

        run_instr(32'h002081B3, 0, 0, 1'b0, 1'b0, -1);   // ADD
        run_instr(32'h4020D093, 0, 0, 1'b0, 1'b0, -1);   // SRAI
        run_instr(32'h402081B3, 1, 0, 1'b0, 1'b0, -1);   // SUB
        run_instr(32'h40000093, 0, 0, 1'b0, 1'b0, -1);   // ADDI with I[30]=1
        run_instr(32'h0020E463, 0, 0, 1'b0, 1'b1, -1);   // BLTU taken
        run_instr(32'h00209463, 0, 0, 1'b1, 1'b0, -1);   // BNE not taken
        run_instr(32'h0000A103, 0, 3, 1'b0, 1'b0, -1);   // LW, 3 wait cycles
        run_instr(32'h0020A023, 2, TMO, 1'b0, 1'b0, -1); // SW, ready on the timeout cycle
        run_instr(32'h0000A103, 0, 3, 1'b0, 1'b0, 1);    // LW, reset on 2nd wait cycle
        run_instr(32'h008000EF, 0, 0, 1'b0, 1'b0, -1);   // JAL
        run_instr(32'h0000007F, 0, 0, 1'b0, 1'b0, -1);   // illegal opcode
        run_instr(32'h0000A103, 0, 99, 1'b0, 1'b0, -1);  // MEM timeout
        run_instr(32'h002081B3, 99, 0, 1'b0, 1'b0, -1);  // FETCH timeout
        run_instr(32'h00001463, 0, 0, 1'b1, 1'b1, -1);   // BNE after reset, not taken

        for (int t = 0; t < 250; t++) begin
            w  = $urandom;
            ci = $urandom_range(0, 9);
            if (ci < 9) begin
                w[6:0] = OPC[ci];
            end else begin
                while (cls_of(w) != C_ILL) w[6:0] = 7'($urandom);
            end
            run_instr(w, $urandom_range(0, TMO), $urandom_range(0, TMO),
                      1'($urandom), 1'($urandom), -1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
